// File: rtl/datapath_bus_pkg.sv
// Shared types for the multicycle RV32 datapath: mux codes, memory sizes, ALU ops, memory FSM
// states and the lane helpers used by the memory controller.
package datapath_bus_pkg;

  typedef enum logic [1:0] {SizeByte = 2'b00, SizeHalf = 2'b01, SizeWord = 2'b10,
                            SizeBad = 2'b11} mem_size_e;

  typedef enum logic [1:0] {OutAluReg, OutAluOut, OutDataReg, OutZero} out_sel_e;
  typedef enum logic [1:0] {SrcAOldPc, SrcAPc, SrcARegA, SrcAZero} src_a_e;
  typedef enum logic [1:0] {SrcBRegB, SrcBImm, SrcBFour, SrcBZero} src_b_e;
  typedef enum logic [2:0] {ImmI, ImmS, ImmB, ImmU, ImmJ} imm_sel_e;

  typedef enum logic [3:0] {AluAdd = 4'd0, AluSub, AluAnd, AluOr, AluXor, AluSll, AluSrl,
                            AluSra, AluSlt, AluSltu} alu_op_e;

  typedef enum logic [0:0] {StIdle, StReq} mem_state_e;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (mem_size_e'(size))
      SizeHalf: return off[0];
      SizeWord: return off != 2'b00;
      SizeBad:  return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
    case (mem_size_e'(size))
      SizeByte: return 4'b0001 << off;
      SizeHalf: return 4'b0011 << off;
      SizeWord: return 4'b1111;
      default:  return 4'b0000;
    endcase
  endfunction

  // lane is the read word already shifted down so the addressed byte sits at bit 0
  function automatic logic [31:0] extend_load(input logic [31:0] lane, input logic [1:0] size,
                                              input logic uns);
    case (mem_size_e'(size))
      SizeByte: return uns ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      SizeHalf: return uns ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default:  return lane;
    endcase
  endfunction

endpackage

// File: rtl/datapath_bus_if.sv
// valid/ready memory bus between the datapath (master) and external memory (slave).
interface datapath_bus_if;
  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/datapath_bus_mem_if_ctrl.sv
// Memory access controller: alignment check, request latching, byte enables, store lane shift
// and load extraction/extension. One outstanding access at a time.
module datapath_bus_mem_if_ctrl
  import datapath_bus_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           mem_req_i,
  input  logic           mem_we_i,
  input  logic           fetch_i,
  input  logic [1:0]     mem_size_i,
  input  logic           mem_unsigned_i,
  input  logic [31:0]    addr_i,
  input  logic [31:0]    store_data_i,
  input  logic [31:0]    pc_i,
  datapath_bus_if.master bus,
  output logic           mem_busy_o,
  output logic           mem_done_o,
  output logic           misalign_o,
  output logic           load_en_o,
  output logic           fetch_en_o,
  output logic [31:0]    load_data_o,
  output logic [31:0]    fetch_data_o,
  output logic [31:0]    fetch_pc_o
);

  mem_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, pc_q, pc_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d, fetch_q, fetch_d, uns_q, uns_d;
  logic        done_q, done_d, mis_q, mis_d;
  logic        req_bad, accept, handshake;
  logic [31:0] lane;

  assign req_bad   = misaligned(mem_size_i, addr_i[1:0]);
  assign accept    = (state_q == StIdle) && mem_req_i && !req_bad;
  assign handshake = (state_q == StReq) && bus.bus_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StReq;
      StReq:   if (bus.bus_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Everything the bus shows is captured at acceptance so it stays stable through wait states
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pc_d    = pc_q;
    be_d    = be_q;
    size_d  = size_q;
    we_d    = we_q;
    fetch_d = fetch_q;
    uns_d   = uns_q;
    done_d  = handshake;
    mis_d   = (state_q == StIdle) && mem_req_i && req_bad;
    if (accept) begin
      addr_d  = addr_i;
      wdata_d = store_data_i << {addr_i[1:0], 3'b000};
      pc_d    = pc_i;
      be_d    = byte_enables(mem_size_i, addr_i[1:0]);
      size_d  = mem_size_i;
      we_d    = mem_we_i;
      fetch_d = fetch_i && !mem_we_i;
      uns_d   = mem_unsigned_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      be_q    <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      fetch_q <= 1'b0;
      uns_q   <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pc_q    <= pc_d;
      be_q    <= be_d;
      size_q  <= size_d;
      we_q    <= we_d;
      fetch_q <= fetch_d;
      uns_q   <= uns_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    bus.bus_valid = (state_q == StReq);
    bus.bus_we    = we_q;
    bus.bus_addr  = {addr_q[31:2], 2'b00};
    bus.bus_be    = be_q;
    bus.bus_wdata = wdata_q;
    mem_busy_o    = (state_q != StIdle);
    mem_done_o    = done_q;
    misalign_o    = mis_q;
    load_en_o     = handshake && !we_q && !fetch_q;
    fetch_en_o    = handshake && fetch_q;
    lane          = bus.bus_rdata >> {addr_q[1:0], 3'b000};
    load_data_o   = extend_load(lane, size_q, uns_q);
    fetch_data_o  = bus.bus_rdata;
    fetch_pc_o    = pc_q;
  end

endmodule

// File: rtl/datapath_bus.sv
// Multicycle RV32 datapath with PC/IR/old-PC, A/B, ALU and data registers, register file and
// an external valid/ready memory bus. Control comes from the external multicycle FSM.
module datapath_bus
  import datapath_bus_pkg::*;
#(
  parameter int unsigned           WORD_SIZE = 32,
  parameter int unsigned           REG_COUNT = 32,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 adr_src,
  input  logic                 pc_write,
  input  logic                 ir_write,
  input  logic                 mem_req,
  input  logic                 mem_we,
  input  logic [1:0]           mem_size,
  input  logic                 mem_unsigned,
  input  logic                 reg_write,
  input  logic                 output_en,
  input  logic [1:0]           out_mux_sel,
  input  logic [2:0]           imm_sel,
  input  logic [1:0]           alu_src_a_sel,
  input  logic [1:0]           alu_src_b_sel,
  input  logic [3:0]           alu_ctrl,
  output logic [6:0]           opcode,
  output logic [2:0]           funct3,
  output logic [6:0]           funct7,
  output logic                 zero_flag,
  output logic                 mem_busy,
  output logic                 mem_done,
  output logic                 misalign,
  output logic [WORD_SIZE-1:0] data_out,
  datapath_bus_if.master       bus
);

  logic [WORD_SIZE-1:0] pc_q, pc_d, ir_q, ir_d, old_pc_q, old_pc_d;
  logic [WORD_SIZE-1:0] a_q, a_d, b_q, b_d, alu_reg_q, alu_reg_d, data_reg_q, data_reg_d;
  logic [WORD_SIZE-1:0] rf_q [REG_COUNT-1:1];
  logic [WORD_SIZE-1:0] rf_d [REG_COUNT-1:1];
  logic [4:0]           rs1, rs2, rd, shamt;
  logic [WORD_SIZE-1:0] rs1_val, rs2_val, imm, src_a, src_b, alu_out, out_bus, mem_addr;
  logic [WORD_SIZE-1:0] load_data, fetch_data, fetch_pc;
  logic                 busy, load_en, fetch_en;

  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign rd     = ir_q[11:7];
  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];

  // x0 has no storage; indices at or above REG_COUNT never match and so read as zero
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    for (int unsigned i = 1; i < REG_COUNT; i++) begin
      if (32'(rs1) == i) rs1_val = rf_q[i];
      if (32'(rs2) == i) rs2_val = rf_q[i];
    end
  end

  always_comb begin
    unique case (imm_sel_e'(imm_sel))
      ImmI:    imm = {{20{ir_q[31]}}, ir_q[31:20]};
      ImmS:    imm = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      ImmB:    imm = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      ImmU:    imm = {ir_q[31:12], 12'h000};
      ImmJ:    imm = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  always_comb begin
    unique case (src_a_e'(alu_src_a_sel))
      SrcAOldPc: src_a = old_pc_q;
      SrcAPc:    src_a = pc_q;
      SrcARegA:  src_a = a_q;
      default:   src_a = '0;
    endcase
    unique case (src_b_e'(alu_src_b_sel))
      SrcBRegB: src_b = b_q;
      SrcBImm:  src_b = imm;
      SrcBFour: src_b = WORD_SIZE'(4);
      default:  src_b = '0;
    endcase
  end

  assign shamt = src_b[4:0];

  always_comb begin
    case (alu_op_e'(alu_ctrl))
      AluAdd:  alu_out = src_a + src_b;
      AluSub:  alu_out = src_a - src_b;
      AluAnd:  alu_out = src_a & src_b;
      AluOr:   alu_out = src_a | src_b;
      AluXor:  alu_out = src_a ^ src_b;
      AluSll:  alu_out = src_a << shamt;
      AluSrl:  alu_out = src_a >> shamt;
      AluSra:  alu_out = $unsigned($signed(src_a) >>> shamt);
      AluSlt:  alu_out = {{(WORD_SIZE-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      AluSltu: alu_out = {{(WORD_SIZE-1){1'b0}}, src_a < src_b};
      default: alu_out = src_b;
    endcase
  end

  assign zero_flag = (alu_out == '0);

  always_comb begin
    unique case (out_sel_e'(out_mux_sel))
      OutAluReg:  out_bus = alu_reg_q;
      OutAluOut:  out_bus = alu_out;
      OutDataReg: out_bus = data_reg_q;
      default:    out_bus = '0;
    endcase
  end

  assign data_out = output_en ? out_bus : '0;
  assign mem_addr = adr_src ? out_bus : pc_q;
  assign mem_busy = busy;

  datapath_bus_mem_if_ctrl u_mem_ctrl (
    .clk            (clk),
    .rst            (rst),
    .mem_req_i      (mem_req),
    .mem_we_i       (mem_we),
    .fetch_i        (ir_write),
    .mem_size_i     (mem_size),
    .mem_unsigned_i (mem_unsigned),
    .addr_i         (mem_addr),
    .store_data_i   (b_q),
    .pc_i           (pc_q),
    .bus            (bus),
    .mem_busy_o     (busy),
    .mem_done_o     (mem_done),
    .misalign_o     (misalign),
    .load_en_o      (load_en),
    .fetch_en_o     (fetch_en),
    .load_data_o    (load_data),
    .fetch_data_o   (fetch_data),
    .fetch_pc_o     (fetch_pc)
  );

  // Architectural state freezes while an access is in flight so the FSM can simply wait
  always_comb begin
    pc_d       = pc_q;
    ir_d       = ir_q;
    old_pc_d   = old_pc_q;
    a_d        = a_q;
    b_d        = b_q;
    alu_reg_d  = alu_reg_q;
    data_reg_d = data_reg_q;
    if (!busy) begin
      a_d       = rs1_val;
      b_d       = rs2_val;
      alu_reg_d = alu_out;
      if (pc_write) pc_d = out_bus;
    end
    if (fetch_en) begin
      ir_d     = fetch_data;
      old_pc_d = fetch_pc;
    end
    if (load_en) data_reg_d = load_data;
  end

  always_comb begin
    rf_d = rf_q;
    for (int unsigned i = 1; i < REG_COUNT; i++) begin
      if (reg_write && !busy && 32'(rd) == i) rf_d[i] = out_bus;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      old_pc_q   <= '0;
      a_q        <= '0;
      b_q        <= '0;
      alu_reg_q  <= '0;
      data_reg_q <= '0;
      for (int unsigned i = 1; i < REG_COUNT; i++) rf_q[i] <= '0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      old_pc_q   <= old_pc_d;
      a_q        <= a_d;
      b_q        <= b_d;
      alu_reg_q  <= alu_reg_d;
      data_reg_q <= data_reg_d;
      rf_q       <= rf_d;
    end
  end

endmodule

// File: tb/tb_datapath_bus.sv
// Directed bench for datapath_bus (REG_COUNT = 16, RESET_PC = 0x100) with a scripted memory slave.
module tb_datapath_bus;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        adr_src, pc_write, ir_write, mem_req, mem_we, mem_unsigned, reg_write, output_en;
  logic [1:0]  mem_size, out_mux_sel, alu_src_a_sel, alu_src_b_sel;
  logic [2:0]  imm_sel;
  logic [3:0]  alu_ctrl;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        zero_flag, mem_busy, mem_done, misalign;
  logic [31:0] data_out;
  int          checks = 0;
  int          errors = 0;

  datapath_bus_if bus_if ();

  datapath_bus #(
    .WORD_SIZE (32),
    .REG_COUNT (16),
    .RESET_PC  (32'h0000_0100)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .adr_src       (adr_src),
    .pc_write      (pc_write),
    .ir_write      (ir_write),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_size      (mem_size),
    .mem_unsigned  (mem_unsigned),
    .reg_write     (reg_write),
    .output_en     (output_en),
    .out_mux_sel   (out_mux_sel),
    .imm_sel       (imm_sel),
    .alu_src_a_sel (alu_src_a_sel),
    .alu_src_b_sel (alu_src_b_sel),
    .alu_ctrl      (alu_ctrl),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7        (funct7),
    .zero_flag     (zero_flag),
    .mem_busy      (mem_busy),
    .mem_done      (mem_done),
    .misalign      (misalign),
    .data_out      (data_out),
    .bus           (bus_if)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Defaults make data_out show PC + 0
  task automatic set_defaults();
    adr_src = 1'b0; pc_write = 1'b0; ir_write = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    mem_size = 2'b10; mem_unsigned = 1'b0; reg_write = 1'b0; output_en = 1'b1;
    out_mux_sel = 2'd1; imm_sel = 3'd0; alu_src_a_sel = 2'd1; alu_src_b_sel = 2'd3;
    alu_ctrl = 4'd0;
  endtask

  // Zero-wait access; address is PC or data_reg. Returns in the mem_done cycle.
  task automatic mem_op(input logic fetch, input logic from_dr, input logic [1:0] size,
                        input logic uns, input logic [31:0] rdata);
    bus_if.bus_ready = 1'b1; bus_if.bus_rdata = rdata;
    ir_write = fetch; adr_src = from_dr; out_mux_sel = from_dr ? 2'd2 : 2'd1;
    mem_size = size; mem_unsigned = uns; mem_we = 1'b0; mem_req = 1'b1;
    step();
    mem_req = 1'b0; ir_write = 1'b0;
    step();
    set_defaults();
  endtask

  task automatic set_dr(input logic [31:0] v);
    mem_op(1'b0, 1'b0, 2'b10, 1'b0, v);
  endtask

  // Writes v to rd of the current IR, then lets A/B pick up the new register values
  task automatic write_rd(input logic [31:0] v);
    set_dr(v);
    reg_write = 1'b1; out_mux_sel = 2'd2;
    step();
    set_defaults();
    step();
  endtask

  task automatic test_reset();
    set_defaults();
    bus_if.bus_ready = 1'b0; bus_if.bus_rdata = '0;
    step(); step();
    rst = 1'b1;
    #1;
    checks++; if (bus_if.bus_valid !== 1'b0) begin errors++;
      $display("FAIL rst_valid got %b expected 0", bus_if.bus_valid); end
    checks++; if ({mem_busy, mem_done, misalign} !== 3'b000) begin errors++;
      $display("FAIL rst_flags got %b expected 000", {mem_busy, mem_done, misalign}); end
    checks++; if ({bus_if.bus_addr, bus_if.bus_be} !== 36'h0) begin errors++;
      $display("FAIL rst_bus got %h expected 0", {bus_if.bus_addr, bus_if.bus_be}); end
    checks++; if ({funct7, funct3, opcode} !== 17'h0) begin errors++;
      $display("FAIL rst_ir got %h expected 0", {funct7, funct3, opcode}); end
    checks++; if (data_out !== 32'h100) begin errors++;
      $display("FAIL rst_pc got %h expected 00000100", data_out); end
    checks++; if (zero_flag !== 1'b0) begin errors++;
      $display("FAIL rst_zero_n got %b expected 0", zero_flag); end
    alu_src_a_sel = 2'd3; output_en = 1'b0;
    #1;
    checks++; if (zero_flag !== 1'b1) begin errors++;
      $display("FAIL rst_zero got %b expected 1", zero_flag); end
    checks++; if (data_out !== 32'h0) begin errors++;
      $display("FAIL out_gate got %h expected 0", data_out); end
    set_defaults();
  endtask

  task automatic test_fetch_zero_wait();
    logic [31:0] instr;
    instr = {7'h55, 5'd3, 5'd5, 3'd5, 5'd5, 7'h33};
    bus_if.bus_ready = 1'b1; bus_if.bus_rdata = instr;
    ir_write = 1'b1; mem_req = 1'b1;
    step();
    mem_req = 1'b0; ir_write = 1'b0;
    checks++; if ({bus_if.bus_valid, mem_busy, mem_done} !== 3'b110) begin errors++;
      $display("FAIL zw_c1 got %b expected 110", {bus_if.bus_valid, mem_busy, mem_done}); end
    checks++; if (bus_if.bus_addr !== 32'h100) begin errors++;
      $display("FAIL zw_addr got %h expected 00000100", bus_if.bus_addr); end
    checks++; if ({bus_if.bus_we, bus_if.bus_be} !== 5'b01111) begin errors++;
      $display("FAIL zw_we_be got %b expected 01111", {bus_if.bus_we, bus_if.bus_be}); end
    step();
    checks++; if ({bus_if.bus_valid, mem_busy, mem_done} !== 3'b001) begin errors++;
      $display("FAIL zw_c2 got %b expected 001", {bus_if.bus_valid, mem_busy, mem_done}); end
    checks++; if ({funct7, funct3, opcode} !== {7'h55, 3'd5, 7'h33}) begin errors++;
      $display("FAIL zw_ir got %h expected %h", {funct7, funct3, opcode}, {7'h55, 3'd5, 7'h33});
    end
    step();
    checks++; if (mem_done !== 1'b0) begin errors++;
      $display("FAIL zw_done_pulse got %b expected 0", mem_done); end
  endtask

  task automatic test_fetch_wait();
    bus_if.bus_ready = 1'b0; bus_if.bus_rdata = {7'h2A, 5'd0, 5'd0, 3'd2, 5'd0, 7'h13};
    ir_write = 1'b1; mem_req = 1'b1;
    step();
    mem_req = 1'b0; ir_write = 1'b0;
    pc_write = 1'b1; alu_src_b_sel = 2'd2;
    for (int k = 0; k < 4; k++) begin
      checks++; if ({bus_if.bus_valid, mem_done, bus_if.bus_addr} !== {2'b10, 32'h100}) begin
        errors++;
        $display("FAIL ws_hold%0d got %b/%b/%h expected 1/0/00000100", k, bus_if.bus_valid,
                 mem_done, bus_if.bus_addr);
      end
      if (k == 3) bus_if.bus_ready = 1'b1;
      step();
    end
    pc_write = 1'b0;
    checks++; if ({bus_if.bus_valid, mem_done} !== 2'b01) begin errors++;
      $display("FAIL ws_done got %b expected 01", {bus_if.bus_valid, mem_done}); end
    checks++; if ({funct7, funct3, opcode} !== {7'h2A, 3'd2, 7'h13}) begin errors++;
      $display("FAIL ws_ir got %h expected %h", {funct7, funct3, opcode}, {7'h2A, 3'd2, 7'h13});
    end
    alu_src_b_sel = 2'd3;
    #1;
    checks++; if (data_out !== 32'h100) begin errors++;
      $display("FAIL ws_pc_held got %h expected 00000100", data_out); end
    step();
    checks++; if (mem_done !== 1'b0) begin errors++;
      $display("FAIL ws_one_done got %b expected 0", mem_done); end
    set_defaults();
  endtask

  task automatic test_load_byte_half();
    set_dr(32'h203);
    out_mux_sel = 2'd2;
    #1;
    checks++; if (data_out !== 32'h203) begin errors++;
      $display("FAIL lw_data got %h expected 00000203", data_out); end
    bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 32'h8000_0000;
    adr_src = 1'b1; mem_size = 2'b00; mem_unsigned = 1'b0; mem_req = 1'b1;
    step();
    mem_req = 1'b0;
    checks++; if ({bus_if.bus_addr, bus_if.bus_be} !== {32'h200, 4'b1000}) begin errors++;
      $display("FAIL lb_bus got %h/%b expected 00000200/1000", bus_if.bus_addr, bus_if.bus_be);
    end
    step();
    #1;
    checks++; if (data_out !== 32'hFFFF_FF80) begin errors++;
      $display("FAIL lb_signed got %h expected ffffff80", data_out); end
    set_defaults();
    set_dr(32'h203);
    mem_op(1'b0, 1'b1, 2'b00, 1'b1, 32'h8000_0000);
    out_mux_sel = 2'd2;
    #1;
    checks++; if (data_out !== 32'h0000_0080) begin errors++;
      $display("FAIL lbu got %h expected 00000080", data_out); end
    set_dr(32'h202);
    mem_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h8001_1234);
    out_mux_sel = 2'd2;
    #1;
    checks++; if (data_out !== 32'hFFFF_8001) begin errors++;
      $display("FAIL lh_signed got %h expected ffff8001", data_out); end
    set_defaults();
  endtask

  task automatic test_store_half();
    mem_op(1'b1, 1'b0, 2'b10, 1'b0, {7'h00, 5'd3, 5'd0, 3'd0, 5'd3, 7'h33});
    write_rd(32'h0000_BEEF);
    set_dr(32'h102);
    bus_if.bus_ready = 1'b0;
    adr_src = 1'b1; out_mux_sel = 2'd2; mem_we = 1'b1; mem_size = 2'b01; mem_req = 1'b1;
    step();
    mem_req = 1'b0;
    checks++; if ({bus_if.bus_valid, bus_if.bus_we, bus_if.bus_be} !== 6'b111100) begin errors++;
      $display("FAIL sh_ctl got %b expected 111100",
               {bus_if.bus_valid, bus_if.bus_we, bus_if.bus_be}); end
    checks++; if (bus_if.bus_wdata !== 32'hBEEF_0000) begin errors++;
      $display("FAIL sh_wdata got %h expected beef0000", bus_if.bus_wdata); end
    checks++; if (bus_if.bus_addr !== 32'h100) begin errors++;
      $display("FAIL sh_addr got %h expected 00000100", bus_if.bus_addr); end
    bus_if.bus_ready = 1'b1;
    step();
    checks++; if ({mem_done, data_out} !== {1'b1, 32'h102}) begin errors++;
      $display("FAIL sh_done got %b/%h expected 1/00000102", mem_done, data_out); end
    set_defaults();
  endtask

  task automatic test_misalign();
    set_dr(32'h101);
    adr_src = 1'b1; out_mux_sel = 2'd2;
    for (int k = 0; k < 3; k++) begin
      // word @0x101, half @0x101, size 11 @0x101
      mem_size = (k == 0) ? 2'b10 : (k == 1) ? 2'b01 : 2'b11;
      mem_req = 1'b1;
      step();
      mem_req = 1'b0;
      checks++; if ({misalign, bus_if.bus_valid, mem_busy} !== 3'b100) begin errors++;
        $display("FAIL mis%0d_pulse got %b expected 100", k,
                 {misalign, bus_if.bus_valid, mem_busy}); end
      step();
      checks++; if ({misalign, bus_if.bus_valid} !== 2'b00) begin errors++;
        $display("FAIL mis%0d_end got %b expected 00", k, {misalign, bus_if.bus_valid}); end
    end
    set_defaults();
  endtask

  task automatic test_regfile();
    mem_op(1'b1, 1'b0, 2'b10, 1'b0, {7'h00, 5'd0, 5'd20, 3'd0, 5'd20, 7'h33});
    write_rd(32'h1234_5678);
    alu_src_a_sel = 2'd2;
    #1;
    checks++; if (data_out !== 32'h0) begin errors++;
      $display("FAIL rf_x20 got %h expected 00000000", data_out); end
    set_defaults();
    mem_op(1'b1, 1'b0, 2'b10, 1'b0, {7'h00, 5'd0, 5'd0, 3'd0, 5'd0, 7'h33});
    write_rd(32'hFFFF_FFFF);
    alu_src_a_sel = 2'd2;
    #1;
    checks++; if (data_out !== 32'h0) begin errors++;
      $display("FAIL rf_x0 got %h expected 00000000", data_out); end
    set_defaults();
    mem_op(1'b1, 1'b0, 2'b10, 1'b0, {7'h00, 5'd0, 5'd5, 3'd0, 5'd5, 7'h33});
    write_rd(32'hCAFE_F00D);
    alu_src_a_sel = 2'd2;
    #1;
    checks++; if (data_out !== 32'hCAFE_F00D) begin errors++;
      $display("FAIL rf_x5 got %h expected cafef00d", data_out); end
    set_defaults();
  endtask

  task automatic test_reset_mid();
    pc_write = 1'b1; alu_src_b_sel = 2'd2;
    step();
    set_defaults();
    #1;
    checks++; if (data_out !== 32'h104) begin errors++;
      $display("FAIL pc_write got %h expected 00000104", data_out); end
    bus_if.bus_ready = 1'b0;
    ir_write = 1'b1; mem_req = 1'b1;
    step();
    mem_req = 1'b0; ir_write = 1'b0;
    checks++; if ({bus_if.bus_valid, bus_if.bus_addr} !== {1'b1, 32'h104}) begin errors++;
      $display("FAIL mid_req got %b/%h expected 1/00000104", bus_if.bus_valid, bus_if.bus_addr);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++; if ({bus_if.bus_valid, mem_busy} !== 2'b00) begin errors++;
      $display("FAIL mid_drop got %b expected 00", {bus_if.bus_valid, mem_busy}); end
    checks++; if (data_out !== 32'h100) begin errors++;
      $display("FAIL mid_pc got %h expected 00000100", data_out); end
    #1;
    rst = 1'b1;
    bus_if.bus_ready = 1'b1;
    step();
    checks++; if ({bus_if.bus_valid, mem_done, opcode} !== 9'h0) begin errors++;
      $display("FAIL mid_abandon got %b/%b/%h expected 0/0/00", bus_if.bus_valid, mem_done,
               opcode); end
    mem_op(1'b1, 1'b0, 2'b10, 1'b0, {7'h01, 5'd0, 5'd0, 3'd7, 5'd0, 7'h6F});
    checks++; if ({mem_done, funct7, funct3, opcode} !== {1'b1, 7'h01, 3'd7, 7'h6F}) begin
      errors++;
      $display("FAIL mid_recover got %h expected %h", {mem_done, funct7, funct3, opcode},
               {1'b1, 7'h01, 3'd7, 7'h6F}); end
  endtask

  initial begin
    test_reset();
    test_fetch_zero_wait();
    test_fetch_wait();
    test_load_byte_half();
    test_store_half();
    test_misalign();
    test_regfile();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
